// File: rtl/risc_eu_p.sv
// risc_eu_p: parametrised execution unit with an NREG x WIDTH register file,
// ALU with N/Z/C/V flags and an iterative shift-add multiplier.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   start, alu_op        issue request and 4-bit operation code
//   rw_en                write result to reg[W_Adr] (sampled with accepted start)
//   W_Adr, R_Adr, S_Adr  destination, R-operand and S-operand addresses
//   s_sel, D_in          S-operand source select (1 = D_in) and memory/immediate data
//   D_out                combinational reg[R_Adr]
//   Y, N, Z, C, V        registered result and status flags
//   busy, done           multiply in progress / one-cycle completion pulse
module risc_eu_p #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREG  = 8,
   parameter int unsigned RA_W  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       alu_op,
   input  logic             rw_en,
   input  logic [RA_W-1:0]  W_Adr,
   input  logic [RA_W-1:0]  R_Adr,
   input  logic [RA_W-1:0]  S_Adr,
   input  logic             s_sel,
   input  logic [WIDTH-1:0] D_in,
   output logic [WIDTH-1:0] D_out,
   output logic [WIDTH-1:0] Y,
   output logic             N,
   output logic             Z,
   output logic             C,
   output logic             V,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned MSB   = WIDTH - 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_MUL  = 1'b1;

   localparam logic [3:0] OP_PASS = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_NOT  = 4'h6;
   localparam logic [3:0] OP_INC  = 4'h7;
   localparam logic [3:0] OP_DEC  = 4'h8;
   localparam logic [3:0] OP_SHL  = 4'h9;
   localparam logic [3:0] OP_SHR  = 4'hA;
   localparam logic [3:0] OP_ASR  = 4'hB;
   localparam logic [3:0] OP_MUL  = 4'hC;

   logic [WIDTH-1:0]   r_regs [NREG];
   logic [0:0]         r_state;
   logic [0:0]         w_state_nxt;
   logic               w_accept;
   logic               w_mul_start;
   logic               w_mul_last;
   logic               w_alu_we;

   logic [WIDTH-1:0]   w_r;
   logic [WIDTH-1:0]   w_s;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH-1:0]   w_res;
   logic               w_c;
   logic               w_v;
   logic               w_valid;

   logic [WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0] r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_mul_rw;
   logic [RA_W-1:0]    r_mul_wadr;
   logic [WIDTH:0]     w_mul_add;
   logic [2*WIDTH-1:0] w_acc_nxt;

   // Read ports: no bypass, reads see the pre-edge register contents
   assign D_out = r_regs[R_Adr];
   assign w_r   = r_regs[R_Adr];
   assign w_s   = s_sel ? D_in : r_regs[S_Adr];
   assign busy  = (r_state == S_MUL);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and issue decode; start is only honoured in IDLE
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_mul_start = 1'b0;
      w_mul_last  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_accept = start;
            if (start && (alu_op == OP_MUL)) begin
               w_mul_start = 1'b1;
               w_state_nxt = S_MUL;
            end
         end
         S_MUL: begin
            if (r_cnt == CNT_W'(1)) begin
               w_mul_last  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Single-cycle ALU; borrow for SUB/DEC is the top bit of the extended difference
   always_comb begin
      w_sum   = '0;
      w_res   = '0;
      w_c     = 1'b0;
      w_v     = 1'b0;
      w_valid = 1'b1;
      case (alu_op)
         OP_PASS: w_res = w_s;
         OP_ADD: begin
            w_sum = {1'b0, w_r} + {1'b0, w_s};
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = (w_r[MSB] == w_s[MSB]) && (w_res[MSB] != w_r[MSB]);
         end
         OP_SUB: begin
            w_sum = {1'b0, w_r} - {1'b0, w_s};
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = (w_r[MSB] != w_s[MSB]) && (w_res[MSB] != w_r[MSB]);
         end
         OP_AND: w_res = w_r & w_s;
         OP_OR:  w_res = w_r | w_s;
         OP_XOR: w_res = w_r ^ w_s;
         OP_NOT: w_res = ~w_r;
         OP_INC: begin
            w_sum = {1'b0, w_r} + (WIDTH+1)'(1);
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = !w_r[MSB] && w_res[MSB];
         end
         OP_DEC: begin
            w_sum = {1'b0, w_r} - (WIDTH+1)'(1);
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = w_r[MSB] && !w_res[MSB];
         end
         OP_SHL: begin
            w_res = {w_r[WIDTH-2:0], 1'b0};
            w_c   = w_r[MSB];
         end
         OP_SHR: begin
            w_res = {1'b0, w_r[WIDTH-1:1]};
            w_c   = w_r[0];
         end
         OP_ASR: begin
            w_res = {w_r[MSB], w_r[WIDTH-1:1]};
            w_c   = w_r[0];
         end
         OP_MUL:  w_valid = 1'b0;
         default: w_valid = 1'b0;
      endcase
   end

   assign w_alu_we = w_accept && w_valid;

   // One shift-add step: conditionally add multiplicand to the upper half, then shift right
   assign w_mul_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_mcand} : (WIDTH+1)'(0));
   assign w_acc_nxt = {w_mul_add, r_acc[WIDTH-1:1]};

   // Multiplier operand latch, accumulator and down-counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mcand    <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_mul_rw   <= 1'b0;
         r_mul_wadr <= '0;
      end else if (w_mul_start) begin
         r_mcand    <= w_r;
         r_acc      <= {{WIDTH{1'b0}}, w_s};
         r_cnt      <= CNT_W'(WIDTH);
         r_mul_rw   <= rw_en;
         r_mul_wadr <= W_Adr;
      end else if (r_state == S_MUL) begin
         r_acc <= w_acc_nxt;
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // Result, flags and completion pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Y    <= '0;
         N    <= 1'b0;
         Z    <= 1'b0;
         C    <= 1'b0;
         V    <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= (w_accept && (alu_op != OP_MUL)) || w_mul_last;
         if (w_alu_we) begin
            Y <= w_res;
            N <= w_res[MSB];
            Z <= (w_res == '0);
            C <= w_c;
            V <= w_v;
         end else if (w_mul_last) begin
            Y <= w_acc_nxt[WIDTH-1:0];
            N <= w_acc_nxt[MSB];
            Z <= (w_acc_nxt[WIDTH-1:0] == '0);
            C <= |w_acc_nxt[2*WIDTH-1:WIDTH];
            V <= 1'b0;
         end
      end
   end

   // Register file; single-cycle and multiply writes never coincide
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else if (w_alu_we && rw_en) begin
         r_regs[W_Adr] <= w_res;
      end else if (w_mul_last && r_mul_rw) begin
         r_regs[r_mul_wadr] <= w_acc_nxt[WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_risc_eu_p.sv
module tb_risc_eu_p;

   localparam int W    = 16;
   localparam int MASK = 32'h0000_FFFF;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  alu_op = '0;
   logic        rw_en = 1'b0;
   logic [2:0]  W_Adr = '0;
   logic [2:0]  R_Adr = '0;
   logic [2:0]  S_Adr = '0;
   logic        s_sel = 1'b0;
   logic [15:0] D_in = '0;
   logic [15:0] D_out;
   logic [15:0] Y;
   logic        N, Z, C, V, busy, done;

   int checks = 0;
   int failures = 0;

   risc_eu_p #(.WIDTH(16), .NREG(8), .RA_W(3)) dut (
      .clk(clk), .reset(reset), .start(start), .alu_op(alu_op), .rw_en(rw_en),
      .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr), .s_sel(s_sel), .D_in(D_in),
      .D_out(D_out), .Y(Y), .N(N), .Z(Z), .C(C), .V(V), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: spec-level register file, flags and multiply countdown
   int      m_reg [8];
   int      m_y;
   bit      m_n, m_z, m_c, m_v, m_busy, m_done;
   int      m_cnt;
   longint  m_prod;
   bit      m_rw;
   int      m_wadr;

   function automatic int sgn(input int x);
      return (x >= 32768) ? x - 65536 : x;
   endfunction

   function automatic bit ovf(input int x);
      return (x > 32767) || (x < -32768);
   endfunction

   function automatic void alu(input int op, input int r, input int s,
                               output int res, output bit c, output bit v, output bit ok);
      ok = 1'b1; c = 1'b0; v = 1'b0; res = 0;
      case (op)
         0:  res = s;
         1:  begin res = (r + s) & MASK; c = (r + s) > MASK; v = ovf(sgn(r) + sgn(s)); end
         2:  begin res = (r - s) & MASK; c = r < s;          v = ovf(sgn(r) - sgn(s)); end
         3:  res = r & s;
         4:  res = r | s;
         5:  res = r ^ s;
         6:  res = (~r) & MASK;
         7:  begin res = (r + 1) & MASK; c = (r == MASK); v = ovf(sgn(r) + 1); end
         8:  begin res = (r - 1) & MASK; c = (r == 0);    v = ovf(sgn(r) - 1); end
         9:  begin res = (r * 2) & MASK; c = (r >> 15) & 1; end
         10: begin res = r >> 1; c = r & 1; end
         11: begin res = (r >> 1) | (r & 32'h8000); c = r & 1; end
         default: ok = 1'b0;
      endcase
   endfunction

   task automatic set_flags(input int res, input bit c, input bit v);
      m_y = res;
      m_n = ((res >> 15) & 1) != 0;
      m_z = (res == 0);
      m_c = c;
      m_v = v;
   endtask

   initial begin : model
      int r, s, res;
      bit c, v, ok;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            for (int i = 0; i < 8; i++) m_reg[i] = 0;
            m_y = 0; m_n = 0; m_z = 0; m_c = 0; m_v = 0;
            m_busy = 0; m_done = 0; m_cnt = 0;
         end else begin
            m_done = 0;
            if (m_busy) begin
               m_cnt--;
               if (m_cnt == 0) begin
                  m_busy = 0;
                  m_done = 1;
                  res = int'(m_prod & MASK);
                  set_flags(res, (m_prod >> 16) != 0, 1'b0);
                  if (m_rw) m_reg[m_wadr] = res;
               end
            end else if (start === 1'b1) begin
               r = m_reg[R_Adr];
               s = s_sel ? int'(D_in) : m_reg[S_Adr];
               if (alu_op == 4'hC) begin
                  m_busy = 1;
                  m_cnt  = W;
                  m_prod = longint'(r) * longint'(s);
                  m_rw   = rw_en;
                  m_wadr = W_Adr;
               end else begin
                  m_done = 1;
                  alu(int'(alu_op), r, s, res, c, v, ok);
                  if (ok) begin
                     set_flags(res, c, v);
                     if (rw_en) m_reg[W_Adr] = res;
                  end
               end
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model
   initial begin : compare
      forever begin
         @(negedge clk);
         chk("d_out", D_out, m_reg[R_Adr]);
         chk("y", Y, m_y);
         chk("n", N, m_n);
         chk("z", Z, m_z);
         chk("c", C, m_c);
         chk("v", V, m_v);
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
      end
   end

   initial begin : watchdog
      #300000;
      failures++;
      $display("FAIL watchdog timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   task automatic drive(input int op, input int w, input int r, input int s,
                        input bit ssel, input int din, input bit rw);
      alu_op = 4'(op); W_Adr = 3'(w); R_Adr = 3'(r); S_Adr = 3'(s);
      s_sel = ssel; D_in = 16'(din); rw_en = rw;
   endtask

   task automatic issue(input int op, input int w, input int r, input int s,
                        input bit ssel, input int din, input bit rw);
      @(posedge clk); #1;
      drive(op, w, r, s, ssel, din, rw);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      rw_en = 1'b0;
   endtask

   task automatic rd_chk(input string name, input int addr, input int exp);
      @(negedge clk); #1;
      R_Adr = 3'(addr);
      #1;
      chk(name, D_out, exp);
      chk({name, "_model"}, m_reg[addr], exp);
   endtask

   typedef struct { int op; int w; int r; int s; bit ssel; int din; } vec_t;
   vec_t tbl [10];

   initial begin : stim
      int n;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // Load and ADD overflow
      issue(0, 1, 0, 0, 1, 'h7FFF, 1);
      @(negedge clk); chk("pass_done", done, 1);
      issue(0, 2, 0, 0, 1, 'h0001, 1);
      issue(1, 3, 1, 2, 0, 0, 1);
      @(negedge clk);
      chk("add_y", Y, 'h8000); chk("add_n", N, 1); chk("add_v", V, 1);
      chk("add_c", C, 0);      chk("add_z", Z, 0); chk("add_done", done, 1);
      @(negedge clk); chk("add_done_pulse", done, 0);

      // Borrow and shifts
      issue(2, 4, 2, 1, 0, 0, 1);
      @(negedge clk);
      chk("sub_y", Y, 'h8002); chk("sub_c", C, 1); chk("sub_n", N, 1); chk("sub_v", V, 0);
      issue(10, 4, 4, 0, 0, 0, 1);
      @(negedge clk); chk("shr_y", Y, 'h4001); chk("shr_c", C, 0);
      issue(9, 7, 3, 0, 0, 0, 1);
      @(negedge clk); chk("shl_y", Y, 0); chk("shl_z", Z, 1); chk("shl_c", C, 1);

      // Multiply with an ignored mid-busy ADD into r6
      issue(0, 0, 0, 0, 1, 'h0123, 1);
      fork
         begin
            issue(12, 5, 0, 0, 1, 'h0100, 1);
            n = 0;
            for (int i = 0; i < 40; i++) begin
               @(negedge clk);
               if (busy) n++;
               else break;
            end
            chk("mul_busy_cycles", n, 16);
            chk("mul_done", done, 1);
            chk("mul_y", Y, 'h2300);
            chk("mul_c", C, 1);
         end
         begin
            repeat (6) @(posedge clk);
            issue(1, 6, 1, 2, 1, 'hFFFF, 1);
         end
      join
      rd_chk("mul_r5", 5, 'h2300);
      rd_chk("ignored_r6", 6, 0);

      // Reset in the middle of a multiply
      issue(12, 5, 0, 0, 1, 'h0200, 1);
      repeat (8) @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (20) @(negedge clk);
      chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_y", Y, 0);
      for (int a = 0; a < 8; a++) rd_chk($sformatf("rst_r%0d", a), a, 0);

      // Reserved opcode leaves state untouched
      issue(0, 1, 0, 0, 1, 'h8000, 1);
      issue(14, 1, 1, 0, 1, 'h5555, 1);
      @(negedge clk);
      chk("rsv_done", done, 1); chk("rsv_y", Y, 'h8000); chk("rsv_n", N, 1);
      @(negedge clk); chk("rsv_done_pulse", done, 0);
      rd_chk("rsv_r1", 1, 'h8000);

      // Back-to-back remaining operations
      tbl[0] = '{op: 0,  w: 2, r: 0, s: 0, ssel: 1, din: 'h7FFF};
      tbl[1] = '{op: 0,  w: 3, r: 0, s: 0, ssel: 1, din: 'h0F0F};
      tbl[2] = '{op: 7,  w: 4, r: 2, s: 0, ssel: 0, din: 0};
      tbl[3] = '{op: 3,  w: 5, r: 3, s: 0, ssel: 1, din: 'h00FF};
      tbl[4] = '{op: 4,  w: 5, r: 3, s: 0, ssel: 1, din: 'hF000};
      tbl[5] = '{op: 5,  w: 6, r: 3, s: 0, ssel: 1, din: 'hFFFF};
      tbl[6] = '{op: 6,  w: 7, r: 3, s: 0, ssel: 0, din: 0};
      tbl[7] = '{op: 8,  w: 0, r: 0, s: 0, ssel: 0, din: 0};
      tbl[8] = '{op: 11, w: 1, r: 1, s: 0, ssel: 0, din: 0};
      tbl[9] = '{op: 1,  w: 2, r: 2, s: 0, ssel: 1, din: 'h8001};
      @(posedge clk);
      foreach (tbl[i]) begin
         #1;
         drive(tbl[i].op, tbl[i].w, tbl[i].r, tbl[i].s, tbl[i].ssel, tbl[i].din, 1);
         start = 1'b1;
         @(posedge clk);
      end
      #1 start = 1'b0; rw_en = 1'b0;
      @(negedge clk);
      chk("add_wrap_z", Z, 1); chk("add_wrap_c", C, 1); chk("add_wrap_v", V, 0);
      rd_chk("inc_r4", 4, 'h8000);
      rd_chk("or_r5", 5, 'hFF0F);
      rd_chk("xor_r6", 6, 'hF0F0);
      rd_chk("not_r7", 7, 'hF0F0);
      rd_chk("dec_r0", 0, 'hFFFF);
      rd_chk("asr_r1", 1, 'hC000);
      rd_chk("add_r2", 2, 0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
